trojan_vector_sequencer: RTL and testbench

- Test controller for one gate-level subcircuit under trojan screening: 5 stimulus inputs, 1 response output, DFFARX1-style internal state.
- Resets the subcircuit, then generates pseudo-random vectors from an LFSR and applies them.
- Waits a programmable settle depth per vector, then compacts each captured response into a MISR signature.
- Compares the final signature against a golden value and reports pass/fail.

---
 rtl/trojan_vector_sequencer.sv | 163 ++++++++++++++++
 tb/tb_trojan_vector_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trojan_vector_sequencer.sv
// Trojan-screening test sequencer for one 5-input / 1-output gate-level subcircuit.
// It resets the subcircuit and applies LFSR vectors. Each captured response bit is folded
// into a 16-bit MISR, and the final signature is compared against a golden value.
module trojan_vector_sequencer #(
    parameter int unsigned       STIM_W         = 5,
    parameter logic [STIM_W-1:0] SEED           = 5'h01,
    parameter int unsigned       SETTLE         = 2,
    parameter int unsigned       DUT_RST_CYCLES = 2,
    parameter int unsigned       CNT_W          = 8
) (
    input  logic              I1470,
    input  logic              I1477,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  vec_count,
    input  logic [15:0]       golden,
    input  logic              dut_resp,
    output logic [STIM_W-1:0] stim,
    output logic              dut_rst_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       signature
);

    typedef enum logic [2:0] {
        StIdle,
        StRstd,
        StApply,
        StWait,
        StCapt,
        StCmp,
        StDone
    } state_e;

    // Last value of the shared wait counter for each timed state.
    localparam logic [3:0] RstLast    = 4'(DUT_RST_CYCLES - 1);
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [STIM_W-1:0]   lfsr_q, lfsr_d;
    logic [STIM_W-1:0]   stim_q, stim_d;
    logic [15:0]         misr_q, misr_d;
    logic [15:0]         gold_q, gold_d;
    logic [CNT_W-1:0]    vnum_q, vnum_d;
    logic [CNT_W-1:0]    vcnt_q, vcnt_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic                pass_q, pass_d;

    logic                run_active;
    logic [CNT_W-1:0]    vcnt_inc;
    logic [STIM_W-1:0]   lfsr_step;
    logic [15:0]         misr_step;

    assign run_active = (state_q != StIdle) && (state_q != StDone);
    assign vcnt_inc   = vcnt_q + CNT_W'(1);
    assign lfsr_step  = {lfsr_q[STIM_W-2:0], lfsr_q[4] ^ lfsr_q[2]};
    assign misr_step  = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000)
                        ^ {15'b0, dut_resp};

    // Next-state logic: abort overrides everything while a run is in progress.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        stim_d  = stim_q;
        misr_d  = misr_q;
        gold_d  = gold_q;
        vnum_d  = vnum_q;
        vcnt_d  = vcnt_q;
        wcnt_d  = wcnt_q;
        pass_d  = pass_q;

        if (abort && run_active) begin
            // Signature keeps its partial value for post-mortem inspection.
            state_d = StIdle;
            stim_d  = '0;
            pass_d  = 1'b0;
            wcnt_d  = '0;
            vcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRstd;
                        vnum_d  = vec_count;
                        gold_d  = golden;
                        misr_d  = '0;
                        lfsr_d  = SEED;
                        stim_d  = '0;
                        pass_d  = 1'b0;
                        wcnt_d  = '0;
                        vcnt_d  = '0;
                    end
                end
                StRstd: begin
                    if (wcnt_q == RstLast) begin
                        wcnt_d  = '0;
                        state_d = (vnum_q != '0) ? StApply : StCmp;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
                StApply: begin
                    stim_d  = lfsr_q;
                    lfsr_d  = lfsr_step;
                    state_d = StWait;
                end
                StWait: begin
                    if (wcnt_q == SettleLast) begin
                        wcnt_d  = '0;
                        state_d = StCapt;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
                StCapt: begin
                    misr_d  = misr_step;
                    vcnt_d  = vcnt_inc;
                    state_d = (vcnt_inc == vnum_q) ? StCmp : StApply;
                end
                StCmp: begin
                    pass_d  = (misr_q == gold_q);
                    stim_d  = '0;
                    state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            stim_q  <= '0;
            misr_q  <= '0;
            gold_q  <= '0;
            vnum_q  <= '0;
            vcnt_q  <= '0;
            wcnt_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            stim_q  <= stim_d;
            misr_q  <= misr_d;
            gold_q  <= gold_d;
            vnum_q  <= vnum_d;
            vcnt_q  <= vcnt_d;
            wcnt_q  <= wcnt_d;
            pass_q  <= pass_d;
        end
    end

    assign stim      = stim_q;
    assign dut_rst_n = (state_q != StRstd);
    assign busy      = run_active;
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_trojan_vector_sequencer.sv
// Scoreboard bench for trojan_vector_sequencer: a driver issues runs and queues the expected
// vectors and final result; a monitor compares them whenever the DUT presents them.
module tb_trojan_vector_sequencer;

    localparam int RST_CYC = 2;
    localparam int VEC_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  vec_count = '0;
    logic [15:0] golden = '0;
    logic        dut_resp;
    logic [4:0]  stim;
    logic        dut_rst_n, busy, done, pass;
    logic [15:0] signature;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Fake subcircuit: response tied low, tied high, or parity of masked stimulus.
    logic [1:0]  resp_mode = 2'd0;
    logic [4:0]  resp_mask = 5'd0;
    assign dut_resp = (resp_mode == 2'd0) ? 1'b0 :
                      (resp_mode == 2'd1) ? 1'b1 : ^(stim & resp_mask);

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  stim_q[$];
    logic [4:0]  m_vecs[$];
    logic [15:0] m_sigs[$];
    logic [15:0] m_sig;

    trojan_vector_sequencer dut (
        .I1470     (clk),
        .I1477     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_count (vec_count),
        .golden    (golden),
        .dut_resp  (dut_resp),
        .stim      (stim),
        .dut_rst_n (dut_rst_n),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_resp(input logic [4:0] v);
        if (resp_mode == 2'd0) return 1'b0;
        if (resp_mode == 2'd1) return 1'b1;
        return ^(v & resp_mask);
    endfunction

    // Reference: walk the vector list from the seed and fold each response into the signature.
    task automatic build_model(input int n);
        logic [4:0]  l;
        logic [15:0] m;
        logic        b;
        l = 5'h01;
        m = 16'h0;
        m_vecs.delete();
        m_sigs.delete();
        for (int i = 0; i < n; i++) begin
            m_vecs.push_back(l);
            b = model_resp(l);
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
            m_sigs.push_back(m);
            l = {l[3:0], l[4] ^ l[2]};
        end
        m_sig = m;
    endtask

    // Issue a start; returns at the negedge after the sampling edge with s = that edge number.
    task automatic launch(input int n, input logic [15:0] g, input bit gold_model, output int s);
        exp_t e;
        logic [15:0] gv;
        build_model(n);
        gv = gold_model ? m_sig : g;
        @(negedge clk);
        start     = 1'b1;
        vec_count = 8'(n);
        golden    = gv;
        @(negedge clk);
        start     = 1'b0;
        s         = cyc;
        vec_count = 8'($urandom);
        golden    = 16'($urandom);
        foreach (m_vecs[i]) stim_q.push_back(m_vecs[i]);
        e.sig      = m_sig;
        e.pass     = (m_sig == gv);
        e.done_cyc = s + RST_CYC + n * VEC_CYC + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", {31'b0, done}, 32'd1);
        if (!done) begin
            stim_q.delete();
            exp_q.delete();
        end
    endtask

    // Monitor: new vectors and rising done are checked against the queued expectations.
    initial begin
        logic [4:0] stim_prev;
        logic       done_prev;
        exp_t       e;
        logic [4:0] sv;
        stim_prev = '0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stim != stim_prev && stim != 5'd0) begin
                    if (stim_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_stim: got %0h, expected none", stim);
                    end else begin
                        sv = stim_q.pop_front();
                        chk("stim_vector", {27'b0, stim}, {27'b0, sv});
                    end
                end
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no run");
                    end else begin
                        e = exp_q.pop_front();
                        chk("signature", {16'b0, signature}, {16'b0, e.sig});
                        chk("pass", {31'b0, pass}, {31'b0, e.pass});
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("all_vectors_seen", stim_q.size(), 0);
                    end
                end
            end
            stim_prev = stim;
            done_prev = done;
        end
    end

    initial begin
        int s;
        int n;
        #12;
        chk("rst_stim", {27'b0, stim}, 32'd0);
        chk("rst_dut_rst_n", {31'b0, dut_rst_n}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pass", {31'b0, pass}, 32'd0);
        chk("rst_signature", {16'b0, signature}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Six vectors, response tied low.
        resp_mode = 2'd0;
        launch(6, 16'h0000, 1'b0, s);
        @(negedge clk);
        chk("rstd_dut_rst_n_low", {31'b0, dut_rst_n}, 32'd0);
        wait_done(40);
        chk("plan6_pass", {31'b0, pass}, 32'd1);

        // Three vectors, response tied high.
        resp_mode = 2'd1;
        launch(3, 16'h0007, 1'b0, s);
        wait_done(30);
        chk("plan3_pass", {31'b0, pass}, 32'd1);
        chk("plan3_sig", {16'b0, signature}, 32'h0007);
        launch(3, 16'h0008, 1'b0, s);
        wait_done(30);
        chk("plan3_fail_pass", {31'b0, pass}, 32'd0);

        // Zero vectors.
        resp_mode = 2'd2;
        resp_mask = 5'h1f;
        launch(0, 16'h0000, 1'b0, s);
        wait_done(10);
        chk("zero_pass", {31'b0, pass}, 32'd1);

        // Abort while done has no effect.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_done_done", {31'b0, done}, 32'd1);
        chk("abort_in_done_pass", {31'b0, pass}, 32'd1);

        // Start from DONE: busy next cycle, pass cleared.
        resp_mask = 5'($urandom);
        launch(2, 16'h0, 1'b1, s);
        chk("redo_busy", {31'b0, busy}, 32'd1);
        chk("redo_pass_clr", {31'b0, pass}, 32'd0);
        chk("redo_done_clr", {31'b0, done}, 32'd0);
        wait_done(20);

        // Start pulses in RSTD and CAPT are ignored.
        resp_mask = 5'($urandom);
        launch(3, 16'h0, 1'b1, s);
        start = 1'b1;
        vec_count = 8'd0;
        golden = ~m_sig;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        vec_count = 8'd1;
        golden = ~m_sig;
        @(negedge clk);
        start = 1'b0;
        wait_done(30);
        chk("ignored_start_pass", {31'b0, pass}, 32'd1);

        // Abort during the settle wait of vector 2.
        resp_mode = 2'd1;
        launch(5, 16'h0, 1'b1, s);
        while (stim_q.size() > 2) void'(stim_q.pop_back());
        void'(exp_q.pop_back());
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_stim", {27'b0, stim}, 32'd0);
        chk("abort_dut_rst_n", {31'b0, dut_rst_n}, 32'd1);
        chk("abort_partial_sig", {16'b0, signature}, {16'b0, m_sigs[0]});
        chk("abort_vectors_seen", stim_q.size(), 0);
        launch(4, 16'h0, 1'b1, s);
        wait_done(30);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 12);
            resp_mode = 2'($urandom_range(0, 2));
            resp_mask = 5'($urandom);
            launch(n, 16'($urandom), 1'($urandom_range(0, 1)), s);
            wait_done(n * VEC_CYC + 20);
        end

        // Longer than the LFSR period, and the maximum count.
        resp_mode = 2'd2;
        resp_mask = 5'h15;
        launch(40, 16'h0, 1'b1, s);
        wait_done(200);
        resp_mask = 5'h0b;
        launch(255, 16'($urandom), 1'b0, s);
        wait_done(255 * VEC_CYC + 20);

        // Asynchronous reset mid-run.
        launch(4, 16'h0, 1'b1, s);
        repeat (4) @(negedge clk);
        chk("mid_run_stim_nonzero", {31'b0, (stim != 5'd0)}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stim", {27'b0, stim}, 32'd0);
        chk("arst_dut_rst_n", {31'b0, dut_rst_n}, 32'd1);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_signature", {16'b0, signature}, 32'd0);
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        launch(3, 16'h0, 1'b1, s);
        wait_done(30);

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
